// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter sequencer.
// Patterns are left-justified in 11 bits, MSB transmitted first.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        GAP
    } state_t;

    localparam logic [2:0] LTR_A = 3'd0;
    localparam logic [2:0] LTR_B = 3'd1;
    localparam logic [2:0] LTR_C = 3'd2;
    localparam logic [2:0] LTR_D = 3'd3;
    localparam logic [2:0] LTR_E = 3'd4;
    localparam logic [2:0] LTR_F = 3'd5;
    localparam logic [2:0] LTR_G = 3'd6;
    localparam logic [2:0] LTR_H = 3'd7;

    localparam logic [10:0] PATTERN [8] = '{
        11'b10111000000,
        11'b11101010100,
        11'b11101011101,
        11'b11101010000,
        11'b10000000000,
        11'b10101110100,
        11'b11101110100,
        11'b10101010000
    };

    localparam logic [3:0] PAT_LEN [8] = '{
        4'd5, 4'd9, 4'd11, 4'd7, 4'd1, 4'd9, 4'd9, 4'd7
    };

    function automatic int tick_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Unit-rate divider: pulses tick once every TICK_DIV enabled cycles.
// clear forces the count back to zero and wins over enable.
module morse_tick_gen
    import morse_pkg::*;
#(
    parameter int TICK_DIV = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = tick_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] div;

    assign tick = enable && (div == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (clear) begin
            div <= '0;
        end else if (enable) begin
            div <= tick ? '0 : div + CW'(1);
        end
    end

endmodule

// File: rtl/morse_sequencer.sv
// Queues letters A-H and shifts their Morse patterns onto DotDashOut,
// one unit per divided tick, with a fixed low gap after each letter.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int TICK_DIV   = 250,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_UNITS  = 3
) (
    input  logic       ClockIn,
    input  logic       Resetn,
    input  logic       Flush,
    input  logic       LetterValid,
    input  logic [2:0] Letter,
    output logic       LetterReady,
    output logic       DotDashOut,
    output logic       Busy,
    output logic       LetterDone
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (GAP_UNITS < 2) ? 1 : $clog2(GAP_UNITS);

    state_t        state, state_n;
    logic [2:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [10:0]   shreg, shreg_n;
    logic [3:0]    remaining, remaining_n;
    logic [GW-1:0] gapcnt, gapcnt_n;
    logic          dd_n, done_n;
    logic          push, pop, tick;
    logic [2:0]    head;

    assign LetterReady = (count < CW'(FIFO_DEPTH));
    assign Busy        = (state != IDLE);
    assign push        = LetterValid && LetterReady && !Flush;
    assign head        = mem[rd_ptr];

    morse_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (ClockIn),
        .rst_n (Resetn),
        .enable((state == SEND) || (state == GAP)),
        .clear (Flush || (state == IDLE) || (state == LOAD)),
        .tick  (tick)
    );

    always_ff @(posedge ClockIn) begin
        if (push) begin
            mem[wr_ptr] <= Letter;
        end
    end

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        remaining_n = remaining;
        gapcnt_n    = gapcnt;
        dd_n        = DotDashOut;
        done_n      = 1'b0;
        pop         = 1'b0;
        if (Flush) begin
            state_n     = IDLE;
            shreg_n     = '0;
            remaining_n = '0;
            gapcnt_n    = '0;
            dd_n        = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (count != '0) state_n = LOAD;
                end
                LOAD: begin
                    pop         = 1'b1;
                    shreg_n     = PATTERN[head];
                    dd_n        = PATTERN[head][10];
                    remaining_n = PAT_LEN[head] - 4'd1;
                    state_n     = SEND;
                end
                SEND: begin
                    if (tick) begin
                        if (remaining == 4'd0) begin
                            dd_n     = 1'b0;
                            gapcnt_n = GW'(GAP_UNITS - 1);
                            state_n  = GAP;
                        end else begin
                            shreg_n     = shreg << 1;
                            dd_n        = shreg[9];
                            remaining_n = remaining - 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gapcnt == '0) begin
                            done_n  = 1'b1;
                            state_n = (count != '0) ? LOAD : IDLE;
                        end else begin
                            gapcnt_n = gapcnt - GW'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            state      <= IDLE;
            shreg      <= '0;
            remaining  <= '0;
            gapcnt     <= '0;
            DotDashOut <= 1'b0;
            LetterDone <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            remaining  <= remaining_n;
            gapcnt     <= gapcnt_n;
            DotDashOut <= dd_n;
            LetterDone <= done_n;
        end
    end

endmodule
